// File: rtl/route_arb_xy.sv
// Round-robin arbiter feeding a single XY-routing stage of a 2D mesh router.
// Optional macro ROUTE_ERR_EN adds destination range checking with an err pulse.
module route_arb_xy #(
  parameter int MESH_X = 4,
  parameter int MESH_Y = 2,
  parameter int NUM_IN = 5,
  parameter int AW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [AW-1:0]        router_add,
  input  logic [NUM_IN-1:0]    req_valid,
  input  logic [NUM_IN*AW-1:0] req_dst,
  output logic [NUM_IN-1:0]    req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_port,
  output logic [2:0]           out_src,
  output logic [AW-1:0]        out_dst,
  output logic                 err
);

  localparam logic [2:0]    PORT_LOCAL = 3'd0;
  localparam logic [2:0]    PORT_EAST  = 3'd1;
  localparam logic [2:0]    PORT_WEST  = 3'd2;
  localparam logic [2:0]    PORT_NORTH = 3'd3;
  localparam logic [2:0]    PORT_SOUTH = 3'd4;
  localparam logic [AW-1:0] MX_L       = AW'(MESH_X);
  localparam logic [2:0]    LAST_IDX   = 3'(NUM_IN - 1);

  // Dimension-ordered routing: resolve X completely before Y.
  function automatic logic [2:0] route_xy(input logic [AW-1:0] dst, input logic [AW-1:0] cur);
    logic [AW-1:0] dx;
    logic [AW-1:0] dy;
    logic [AW-1:0] cx;
    logic [AW-1:0] cy;
    dx = dst % MX_L;
    dy = dst / MX_L;
    cx = cur % MX_L;
    cy = cur / MX_L;
    if (dx > cx) begin
      route_xy = PORT_EAST;
    end else if (dx < cx) begin
      route_xy = PORT_WEST;
    end else if (dy > cy) begin
      route_xy = PORT_NORTH;
    end else if (dy < cy) begin
      route_xy = PORT_SOUTH;
    end else begin
      route_xy = PORT_LOCAL;
    end
  endfunction

  logic [2:0]    r_rr_ptr;
  logic          r_out_valid;
  logic [2:0]    r_out_port;
  logic [2:0]    r_out_src;
  logic [AW-1:0] r_out_dst;

  logic          w_found;
  logic [2:0]    w_gidx;
  logic          w_can_grant;
  logic          w_grant;
  logic [AW-1:0] w_gdst;
  logic [2:0]    w_next_ptr;
  logic [2:0]    w_route;
  logic          w_bad;

  // Rotating priority search starting at the round-robin pointer.
  always_comb begin
    logic [7:0] w_req8;
    logic [3:0] w_cand;
    w_req8  = 8'(req_valid);
    w_cand  = 4'd0;
    w_found = 1'b0;
    w_gidx  = r_rr_ptr;
    for (int k = 0; k < NUM_IN; k++) begin
      w_cand  = {1'b0, r_rr_ptr} + 4'(k);
      w_cand  = (w_cand >= 4'(NUM_IN)) ? (w_cand - 4'(NUM_IN)) : w_cand;
      w_gidx  = (!w_found && w_req8[w_cand[2:0]]) ? w_cand[2:0] : w_gidx;
      w_found = w_found | w_req8[w_cand[2:0]];
    end
  end

  assign w_can_grant = en & ~rst & (~r_out_valid | out_ready);
  assign w_grant     = w_can_grant & w_found;
  assign w_next_ptr  = (w_gidx == LAST_IDX) ? 3'd0 : (w_gidx + 3'd1);
  assign w_route     = route_xy(w_gdst, router_add);

  always_comb begin
    w_gdst = {AW{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      w_gdst = w_gdst | (req_dst[i*AW +: AW] & {AW{w_gidx == 3'(i)}});
    end
  end

  always_comb begin
    if (w_grant) begin
      req_ready = NUM_IN'(8'd1 << w_gidx);
    end else begin
      req_ready = {NUM_IN{1'b0}};
    end
  end

`ifdef ROUTE_ERR_EN
  localparam logic [AW:0] NODES = (AW+1)'(MESH_X * MESH_Y);
  logic r_err;

  assign w_bad = ({1'b0, w_gdst} >= NODES);
  assign err   = r_err;

  // A granted out-of-mesh request is consumed and reported instead of routed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_grant & w_bad;
    end
  end
`else
  assign w_bad = 1'b0;
  assign err   = 1'b0;
`endif

  // Output stage holds its result until accepted; a grant refills it in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_port  <= 3'd0;
      r_out_src   <= 3'd0;
      r_out_dst   <= {AW{1'b0}};
    end else if (w_grant) begin
      r_rr_ptr    <= w_next_ptr;
      r_out_valid <= ~w_bad;
      if (!w_bad) begin
        r_out_port <= w_route;
        r_out_src  <= w_gidx;
        r_out_dst  <= w_gdst;
      end
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_port  = r_out_port;
  assign out_src   = r_out_src;
  assign out_dst   = r_out_dst;

endmodule

// File: tb/tb_route_arb_xy.sv
// Randomized scoreboard bench for route_arb_xy; adapts mesh size when ROUTE_ERR_EN is defined.
module tb_route_arb_xy;

`ifdef ROUTE_ERR_EN
  localparam int MX     = 3;
  localparam int MY     = 3;
  localparam int AWT    = 4;
  localparam bit ERR_ON = 1'b1;
`else
  localparam int MX     = 4;
  localparam int MY     = 2;
  localparam int AWT    = 3;
  localparam bit ERR_ON = 1'b0;
`endif
  localparam int NI    = 5;
  localparam int NODES = MX * MY;

  typedef struct {
    int port;
    int src;
    int dst;
  } exp_t;

  exp_t exp_q[$];

  logic                clk        = 1'b0;
  logic                rst        = 1'b1;
  logic                en         = 1'b0;
  logic [AWT-1:0]      router_add = {AWT{1'b0}};
  logic [NI-1:0]       req_valid  = {NI{1'b0}};
  logic [NI*AWT-1:0]   req_dst    = {(NI*AWT){1'b0}};
  logic                out_ready  = 1'b0;
  logic [NI-1:0]       req_ready;
  logic                out_valid;
  logic [2:0]          out_port;
  logic [2:0]          out_src;
  logic [AWT-1:0]      out_dst;
  logic                err;

  int n_tot = 0;
  int n_bad = 0;
  int m_rr = 0;
  bit m_valid = 1'b0;
  bit m_err_pend = 1'b0;
  bit m_prev_rst = 1'b1;
  int ra_cur = 0;

  route_arb_xy #(.MESH_X(MX), .MESH_Y(MY), .NUM_IN(NI), .AW(AWT)) dut (
    .clk(clk), .rst(rst), .en(en), .router_add(router_add),
    .req_valid(req_valid), .req_dst(req_dst), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
    .out_src(out_src), .out_dst(out_dst), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int route_ref(int dst, int cur);
    int dx = dst % MX;
    int dy = dst / MX;
    int cx = cur % MX;
    int cy = cur / MX;
    if (dx > cx) return 1;
    if (dx < cx) return 2;
    if (dy > cy) return 3;
    if (dy < cy) return 4;
    return 0;
  endfunction

  function automatic logic [NI*AWT-1:0] one_dst(int ch, int a);
    logic [NI*AWT-1:0] v = {(NI*AWT){1'b0}};
    v[ch*AWT +: AWT] = AWT'(a);
    return v;
  endfunction

  function automatic logic [NI*AWT-1:0] rand_dsts();
    logic [NI*AWT-1:0] v = {(NI*AWT){1'b0}};
    for (int k = 0; k < NI; k++) v[k*AWT +: AWT] = AWT'($urandom_range(0, (1 << AWT) - 1));
    return v;
  endfunction

  // One clock of stimulus: check registered state, drive, predict, check the grant.
  task automatic step(input bit r, input bit e, input logic [NI-1:0] v,
                      input logic [NI*AWT-1:0] d, input bit ordy, input int ra);
    int g;
    int dst;
    logic [NI-1:0] exp_rdy;
    exp_t it;
    @(posedge clk);
    #1;
    n_tot++;
    if (err !== m_err_pend) begin
      n_bad++;
      $display("FAIL err: got %b want %b", err, m_err_pend);
    end
    if (m_prev_rst) begin
      n_tot++;
      if (out_valid !== 1'b0 || out_port !== 3'd0 || out_src !== 3'd0 || out_dst !== {AWT{1'b0}}) begin
        n_bad++;
        $display("FAIL reset_state: got v=%b p=%0d s=%0d d=%0d want all 0", out_valid, out_port, out_src, out_dst);
      end
    end
    #1;
    rst = r; en = e; req_valid = v; req_dst = d; out_ready = ordy; router_add = AWT'(ra);
    #1;
    g = -1;
    exp_rdy = {NI{1'b0}};
    m_err_pend = 1'b0;
    if (r) begin
      m_rr = 0;
      m_valid = 1'b0;
      exp_q.delete();
    end else begin
      if (e && (!m_valid || ordy)) begin
        for (int k = 0; k < NI; k++) begin
          int c = (m_rr + k) % NI;
          if (g < 0 && v[c]) g = c;
        end
      end
      if (g >= 0) begin
        exp_rdy[g] = 1'b1;
        m_rr = (g + 1) % NI;
        dst = int'(d[g*AWT +: AWT]);
        if (ERR_ON && dst >= NODES) begin
          m_err_pend = 1'b1;
          m_valid = 1'b0;
        end else begin
          it.port = route_ref(dst, ra);
          it.src = g;
          it.dst = dst;
          exp_q.push_back(it);
          m_valid = 1'b1;
        end
      end else if (ordy) begin
        m_valid = 1'b0;
      end
    end
    m_prev_rst = r;
    n_tot++;
    if (req_ready !== exp_rdy) begin
      n_bad++;
      $display("FAIL req_ready: got %b want %b", req_ready, exp_rdy);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1) begin
        n_tot++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL out_result: got p=%0d s=%0d d=%0d want no result", out_port, out_src, out_dst);
        end else begin
          if (out_port !== 3'(exp_q[0].port) || out_src !== 3'(exp_q[0].src) || out_dst !== AWT'(exp_q[0].dst)) begin
            n_bad++;
            $display("FAIL out_result: got p=%0d s=%0d d=%0d want p=%0d s=%0d d=%0d",
                     out_port, out_src, out_dst, exp_q[0].port, exp_q[0].src, exp_q[0].dst);
          end
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [NI*AWT-1:0] d;
    repeat (3) step(1'b1, 1'b0, 5'b00000, {(NI*AWT){1'b0}}, 1'b0, 0);

    // Far corner from node 0, then local/south cases from node 5.
    step(1'b0, 1'b1, 5'b00001, one_dst(0, 7), 1'b1, 0);
    step(1'b0, 1'b0, 5'b00000, {(NI*AWT){1'b0}}, 1'b1, 0);
    step(1'b0, 1'b1, 5'b00001, one_dst(0, 1), 1'b1, 5);
    step(1'b0, 1'b1, 5'b00001, one_dst(0, 5), 1'b1, 5);
    step(1'b0, 1'b0, 5'b00000, {(NI*AWT){1'b0}}, 1'b1, 5);

    d = rand_dsts();
    repeat (7) step(1'b0, 1'b1, 5'b11111, d, 1'b1, 0);
    repeat (3) step(1'b0, 1'b1, 5'b11111, d, 1'b0, 3);
    step(1'b0, 1'b1, 5'b11111, d, 1'b1, 3);
    step(1'b0, 1'b1, 5'b11111, d, 1'b0, 3);
    step(1'b0, 1'b0, 5'b11111, d, 1'b1, 3);
    step(1'b0, 1'b0, 5'b11111, d, 1'b1, 3);

`ifdef ROUTE_ERR_EN
    step(1'b0, 1'b1, 5'b00001, one_dst(0, NODES), 1'b1, 4);
    step(1'b0, 1'b1, 5'b00001, one_dst(0, 12), 1'b1, 4);
    step(1'b0, 1'b1, 5'b00001, one_dst(0, NODES - 1), 1'b1, 4);
    repeat (2) step(1'b0, 1'b0, 5'b00000, {(NI*AWT){1'b0}}, 1'b1, 4);
`endif

    // Reset while a result is held, then grant from a partly-valid set.
    step(1'b0, 1'b1, 5'b11111, d, 1'b0, 0);
    step(1'b0, 1'b1, 5'b11111, d, 1'b0, 0);
    step(1'b0, 1'b1, 5'b11111, d, 1'b0, 0);
    step(1'b1, 1'b1, 5'b11111, d, 1'b0, 0);
    step(1'b0, 1'b1, 5'b10110, d, 1'b1, 0);
    step(1'b0, 1'b0, 5'b00000, d, 1'b1, 0);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) ra_cur = $urandom_range(0, NODES - 1);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0, NI'($urandom),
           rand_dsts(), $urandom_range(0, 3) != 0, ra_cur);
    end

    repeat (3) step(1'b0, 1'b0, 5'b00000, {(NI*AWT){1'b0}}, 1'b1, ra_cur);
    n_tot++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d outstanding results want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/route_arb_xy.md
ROUTE_ARB_XY -- requirements
Module: route_arb_xy

Interface
REQ-001 SHALL have parameter MESH_X, default 4, mesh columns.
REQ-002 SHALL have parameter MESH_Y, default 2, mesh rows.
REQ-003 SHALL have parameter NUM_IN, default 5, requesting input channels (2..8).
REQ-004 SHALL have parameter AW, default 3, address width; 2^AW >= MESH_X*MESH_Y.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  grant enable.
REQ-008 SHALL have port router_add  input  AW  this router's address, sampled every cycle.
REQ-009 SHALL have port req_valid  input  NUM_IN  per-channel request.
REQ-010 SHALL have port req_dst  input  NUM_IN*AW  per-channel destination; channel i at bits [i*AW +: AW].
REQ-011 SHALL have port req_ready  output  NUM_IN  one-hot grant, combinational.
REQ-012 SHALL have port out_valid  output  1  routed result valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port out_port  output  3  0 LOCAL, 1 EAST, 2 WEST, 3 NORTH, 4 SOUTH.
REQ-015 SHALL have port out_src  output  3  granted channel index.
REQ-016 SHALL have port out_dst  output  AW  destination of result.
REQ-017 SHALL have port err  output  1  bad-destination pulse (ROUTE_ERR_EN only).

Function
REQ-018 SHALL decode address A as x = A mod MESH_X, y = A div MESH_X.
REQ-019 SHALL route XY: dst_x>cur_x EAST; dst_x<cur_x WEST; else dst_y>cur_y NORTH; dst_y<cur_y SOUTH; else LOCAL.
REQ-020 SHALL grant at most one channel per cycle, only when en=1 and (out_valid=0 or out_ready=1).
REQ-021 SHALL arbitrate round-robin: search starts at rr_ptr, rr_ptr <= granted index+1 (wraps NUM_IN-1 -> 0) on each grant.
REQ-022 SHALL register the grant's port/src/dst and set out_valid on the edge after grant (latency 1).
REQ-023 SHALL hold out_port/out_src/out_dst stable while out_valid=1 and out_ready=0.
REQ-024 SHALL clear out_valid after a handshake cycle with no new grant; handshake plus grant in one cycle gives back-to-back results.
REQ-025 SHALL, with en=0, issue no grants but still complete a pending output handshake.
REQ-026 SHALL keep rr_ptr unchanged on cycles with no grant.
REQ-027 SHALL use current router_add at grant time; changing it does not alter a held result.

Reset
REQ-028 SHALL, while rst=1 at an edge, set out_valid=0, out_port=0, out_src=0, out_dst=0, err=0, rr_ptr=0.
REQ-029 SHALL hold req_ready=0 while rst=1; reset mid-handshake discards the held result.

Configuration
REQ-030 SHALL compile destination checking only when macro ROUTE_ERR_EN is defined.
REQ-031 SHALL, with ROUTE_ERR_EN, on grant of dst >= MESH_X*MESH_Y: pulse err for one cycle, consume the request, produce no out_valid.
REQ-032 SHALL, without ROUTE_ERR_EN, tie err to 0 and route any dst per REQ-019 without check.

Verification
REQ-033 SHALL cover: defaults, router_add=0, ch0 dst=7 -> out_port=1 EAST one cycle later, out_src=0.
REQ-034 SHALL cover: router_add=5, dst=1 -> NORTH... no: dst=1 (x1,y0), cur (x1,y1) -> out_port=4 SOUTH; dst=5 -> LOCAL.
REQ-035 SHALL cover: all 5 channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,4,0 with no gaps.
REQ-036 SHALL cover: out_ready=0 for 3 cycles -> outputs stable, req_ready=0, rr_ptr frozen; release -> next grant next cycle.
REQ-037 SHALL cover: MESH_X=3, MESH_Y=3, AW=4, ROUTE_ERR_EN, dst=12 -> err=1 for one cycle, out_valid stays 0.
REQ-038 SHALL cover: rst=1 asserted while out_valid=1 -> next edge out_valid=0, rr_ptr=0, first post-reset grant to lowest valid channel.
